// File: rtl/calc_sequencer_if.sv
// Bundle of the pin-side byte stream, ALU control/result and consumer
// result handshake seen by the calculator sequencer.
interface calc_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_op;
  logic              alu_start;
  logic              alu_done;
  logic [RES_W-1:0]  alu_result;
  logic [RES_W-1:0]  res_data;
  logic [1:0]        res_err;
  logic              res_valid;
  logic              res_ready;
  logic              busy;

  // Sequencer side: drives the ALU and the result handshake.
  modport master (
    input  in_data, in_valid, alu_done, alu_result, res_ready,
    output in_ready, alu_a, alu_b, alu_op, alu_start,
           res_data, res_err, res_valid, busy
  );

  // Environment side: pin wrapper, ALU and result consumer.
  modport slave (
    output in_data, in_valid, alu_done, alu_result, res_ready,
    input  in_ready, alu_a, alu_b, alu_op, alu_start,
           res_data, res_err, res_valid, busy
  );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator sequencer: collects A, B and opcode bytes, issues a single
// ALU start, waits for done (with timeout) and holds the result until the
// consumer accepts it. Bad opcode and divide-by-zero are rejected without
// touching the ALU.
module calc_sequencer #(
  parameter int DATA_W     = 8,
  parameter int RES_W      = 16,
  parameter int NUM_OPS    = 6,
  parameter int DIV_OPCODE = 3,
  parameter int TIMEOUT    = 31
) (
  input  logic                clk,
  input  logic                rst,
  calc_sequencer_if.master    bus
);

  localparam int         CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [3:0] NUM_OPS_L  = 4'(NUM_OPS);
  localparam logic [2:0] DIV_OP_L   = 3'(DIV_OPCODE);
  localparam logic [CNT_W-1:0] TIMEOUT_L = CNT_W'(TIMEOUT);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_BAD_OP  = 2'b01;
  localparam logic [1:0] ERR_DIV0    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_LOAD_A,
    S_LOAD_B,
    S_LOAD_OP,
    S_ISSUE,
    S_WAIT,
    S_RESULT
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [RES_W-1:0]   res_data_q, res_data_d;
  logic [1:0]         res_err_q, res_err_d;
  logic               res_valid_q, res_valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_c;
  logic               alu_start_c;
  logic [2:0]         op_in;

  assign op_in = bus.in_data[2:0];

  // State register and all held values; reset returns everything to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD_A;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_data_q  <= '0;
      res_err_q   <= ERR_OK;
      res_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state logic, operand capture, error decisions and the start pulse.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    res_valid_d = res_valid_q;
    cnt_d       = cnt_q;
    in_ready_c  = 1'b0;
    alu_start_c = 1'b0;

    case (state_q)
      S_LOAD_A: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          a_d     = bus.in_data;
          state_d = S_LOAD_B;
        end
      end

      S_LOAD_B: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          b_d     = bus.in_data;
          state_d = S_LOAD_OP;
        end
      end

      S_LOAD_OP: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          op_d = op_in;
          if ({1'b0, op_in} >= NUM_OPS_L) begin
            res_err_d   = ERR_BAD_OP;
            res_data_d  = '0;
            res_valid_d = 1'b1;
            state_d     = S_RESULT;
          end else if (op_in == DIV_OP_L && b_q == '0) begin
            // Divide-by-zero is caught here so the ALU never sees it.
            res_err_d   = ERR_DIV0;
            res_data_d  = '0;
            res_valid_d = 1'b1;
            state_d     = S_RESULT;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        alu_start_c = 1'b1;
        cnt_d       = '0;
        state_d     = S_WAIT;
      end

      S_WAIT: begin
        // done takes priority over the final timeout cycle
        if (bus.alu_done) begin
          res_data_d  = bus.alu_result;
          res_err_d   = ERR_OK;
          res_valid_d = 1'b1;
          state_d     = S_RESULT;
        end else if (cnt_q == TIMEOUT_L) begin
          res_err_d   = ERR_TIMEOUT;
          res_data_d  = '0;
          res_valid_d = 1'b1;
          state_d     = S_RESULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RESULT: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_LOAD_A;
        end
      end

      default: begin
        state_d = S_LOAD_A;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.alu_start = alu_start_c;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_op    = op_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_err   = res_err_q;
  assign bus.res_valid = res_valid_q;
  assign bus.busy      = (state_q != S_LOAD_A);

endmodule
